// File: rtl/sockit_spi_rsq_if.sv
// Handshake bundle between the SPI request sequencer, its descriptor source,
// the serializer feeding it, and the repackager it drives.
interface sockit_spi_rsq_if #(
  parameter int QCI = 4,
  parameter int QDW = 32,
  parameter int LNW = 16
);
  logic           dsc_vld;
  logic [1:0]     dsc_iom;
  logic [LNW-1:0] dsc_len;
  logic           dsc_rdy;
  logic           abt;
  logic           ser_vld;
  logic [QDW-1:0] ser_dat;
  logic           ser_rdy;
  logic           que_vld;
  logic [QCI-1:0] que_ctl;
  logic [QDW-1:0] que_dat;
  logic           que_rdy;
  logic           sts_bsy;
  logic [LNW-1:0] sts_rem;

  modport slave (
    input  dsc_vld, dsc_iom, dsc_len, abt, ser_vld, ser_dat, que_rdy,
    output dsc_rdy, ser_rdy, que_vld, que_ctl, que_dat, sts_bsy, sts_rem
  );

  modport master (
    output dsc_vld, dsc_iom, dsc_len, abt, ser_vld, ser_dat, que_rdy,
    input  dsc_rdy, ser_rdy, que_vld, que_ctl, que_dat, sts_bsy, sts_rem
  );
endinterface

// File: rtl/sockit_spi_rsq.sv
// SPI request sequencer: accepts a descriptor, then passes serializer segments
// straight to the repackager queue, tagging word-start/word-end and IO mode.
module sockit_spi_rsq #(
  parameter int SDW = 8,
  parameter int QCI = 4,
  parameter int QDW = 4*SDW,
  parameter int LNW = 16
) (
  input  logic              clk,
  input  logic              rst,
  sockit_spi_rsq_if.slave   bus
);

  typedef enum logic {IDL = 1'b0, RUN = 1'b1} state_t;

  state_t         state;
  logic [LNW-1:0] rem;
  logic [1:0]     wct;
  logic           fst;
  logic [1:0]     iom;
  logic           dsc_rdy_q;
  logic           bsy_q;

  logic           run;
  logic           lst;
  logic           xfr;
  logic [QCI-1:0] ctl;
  logic [QDW-1:0] dat;

  // Index of the last segment within one output word for a given IO mode
  // (segments per word minus one: 4 for 3-wire/SPI, 2 for dual, 1 for quad).
  function automatic logic [1:0] wct_last(input logic [1:0] mode);
    case (mode)
      2'd2:    wct_last = 2'd1;
      2'd3:    wct_last = 2'd0;
      default: wct_last = 2'd3;
    endcase
  endfunction

  assign run = (state == RUN);
  assign lst = (rem == '0) | (wct == wct_last(iom));
  assign xfr = run & bus.ser_vld & bus.que_rdy & ~bus.abt;
  assign ctl = {fst, lst, iom};
  assign dat = bus.ser_dat;

  // Zero-latency pass-through of the segment stream while a descriptor runs.
  assign bus.que_vld = run & bus.ser_vld & ~bus.abt;
  assign bus.ser_rdy = run & bus.que_rdy & ~bus.abt;
  assign bus.que_ctl = ctl;
  assign bus.que_dat = dat;
  assign bus.dsc_rdy = dsc_rdy_q;
  assign bus.sts_bsy = bsy_q;
  assign bus.sts_rem = bsy_q ? rem : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDL;
      rem       <= '0;
      wct       <= 2'd0;
      fst       <= 1'b0;
      iom       <= 2'd0;
      dsc_rdy_q <= 1'b1;
      bsy_q     <= 1'b0;
    end else begin
      case (state)
        IDL: begin
          if (bus.dsc_vld) begin
            state     <= RUN;
            iom       <= bus.dsc_iom;
            rem       <= bus.dsc_len;
            wct       <= 2'd0;
            fst       <= 1'b1;
            dsc_rdy_q <= 1'b0;
            bsy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abt) begin
            state     <= IDL;
            rem       <= '0;
            wct       <= 2'd0;
            fst       <= 1'b0;
            dsc_rdy_q <= 1'b1;
            bsy_q     <= 1'b0;
          end else if (xfr) begin
            fst <= 1'b0;
            wct <= lst ? 2'd0 : wct + 2'd1;
            // rem==0 marks the final segment; hold it there instead of wrapping.
            if (rem == '0) begin
              state     <= IDL;
              dsc_rdy_q <= 1'b1;
              bsy_q     <= 1'b0;
            end else begin
              rem <= rem - LNW'(1);
            end
          end
        end
        default: begin
          state     <= IDL;
          dsc_rdy_q <= 1'b1;
          bsy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sockit_spi_rsq.sv
// Directed bench for sockit_spi_rsq: descriptor sequencing, word tagging,
// backpressure, abort, asynchronous reset and back-to-back descriptors.
module tb_sockit_spi_rsq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec = 0;
  int   mis = 0;
  logic [1:0] cur_iom = 2'd0;

  sockit_spi_rsq_if #(.QCI(4), .QDW(32), .LNW(16)) bus ();

  sockit_spi_rsq #(.SDW(8), .QCI(4), .QDW(32), .LNW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every step enters 1 time unit after a rising edge and leaves likewise.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_dsc_rdy"}, 32'(bus.dsc_rdy), 32'd1);
    chk({tag, "_que_vld"}, 32'(bus.que_vld), 32'd0);
    chk({tag, "_ser_rdy"}, 32'(bus.ser_rdy), 32'd0);
    chk({tag, "_sts_bsy"}, 32'(bus.sts_bsy), 32'd0);
    chk({tag, "_sts_rem"}, 32'(bus.sts_rem), 32'd0);
  endtask

  task automatic offer(input string tag, input logic [1:0] iom, input logic [15:0] len,
                       input logic hold);
    bus.dsc_vld = 1'b1;
    bus.dsc_iom = iom;
    bus.dsc_len = len;
    cur_iom     = iom;
    #2;
    chk({tag, "_acc_rdy"}, 32'(bus.dsc_rdy), 32'd1);
    next_edge();
    if (!hold) bus.dsc_vld = 1'b0;
    bus.abt = 1'b0;
    #1;
    chk({tag, "_bsy"}, 32'(bus.sts_bsy), 32'd1);
    chk({tag, "_rem0"}, 32'(bus.sts_rem), 32'(len));
    chk({tag, "_dsc_rdy_run"}, 32'(bus.dsc_rdy), 32'd0);
  endtask

  task automatic seg(input string tag, input logic nw, input logic ls, input logic [15:0] rem);
    logic [31:0] d;
    d = $urandom;
    bus.ser_vld = 1'b1;
    bus.que_rdy = 1'b1;
    bus.ser_dat = d;
    #2;
    chk({tag, "_vld"}, 32'(bus.que_vld), 32'd1);
    chk({tag, "_rdy"}, 32'(bus.ser_rdy), 32'd1);
    chk({tag, "_ctl"}, 32'(bus.que_ctl), 32'({nw, ls, cur_iom}));
    chk({tag, "_dat"}, bus.que_dat, d);
    chk({tag, "_rem"}, 32'(bus.sts_rem), 32'(rem));
    next_edge();
  endtask

  initial begin
    bus.dsc_vld = 1'b0;
    bus.dsc_iom = 2'd0;
    bus.dsc_len = '0;
    bus.abt     = 1'b0;
    bus.ser_vld = 1'b1;
    bus.ser_dat = '0;
    bus.que_rdy = 1'b1;

    // Reset state, with a segment pending to prove it is not forwarded.
    #12;
    idle_chk("rst");
    rst = 1'b1;
    next_edge();
    idle_chk("post_rst");

    // SPI, 8 segments: two 4-segment words.
    offer("spi8", 2'd1, 16'd7, 1'b0);
    seg("spi8_s0", 1'b1, 1'b0, 16'd7);
    seg("spi8_s1", 1'b0, 1'b0, 16'd6);
    seg("spi8_s2", 1'b0, 1'b0, 16'd5);
    seg("spi8_s3", 1'b0, 1'b1, 16'd4);
    seg("spi8_s4", 1'b0, 1'b0, 16'd3);
    seg("spi8_s5", 1'b0, 1'b0, 16'd2);
    seg("spi8_s6", 1'b0, 1'b0, 16'd1);
    seg("spi8_s7", 1'b0, 1'b1, 16'd0);
    idle_chk("spi8_end");

    // Quad, 3 segments: every segment closes a word.
    offer("quad3", 2'd3, 16'd2, 1'b0);
    seg("quad3_s0", 1'b1, 1'b1, 16'd2);
    seg("quad3_s1", 1'b0, 1'b1, 16'd1);
    seg("quad3_s2", 1'b0, 1'b1, 16'd0);
    idle_chk("quad3_end");

    // Dual, 3 segments, queue stalls for 3 cycles after the first segment.
    offer("dual3", 2'd2, 16'd2, 1'b0);
    seg("dual3_s0", 1'b1, 1'b0, 16'd2);
    for (int i = 0; i < 3; i++) begin
      bus.que_rdy = 1'b0;
      bus.ser_vld = 1'b1;
      #2;
      chk("dual3_stall_rdy", 32'(bus.ser_rdy), 32'd0);
      chk("dual3_stall_vld", 32'(bus.que_vld), 32'd1);
      chk("dual3_stall_ctl", 32'(bus.que_ctl), 32'b0110);
      chk("dual3_stall_rem", 32'(bus.sts_rem), 32'd1);
      next_edge();
    end
    seg("dual3_s1", 1'b0, 1'b1, 16'd1);
    seg("dual3_s2", 1'b0, 1'b1, 16'd0);
    idle_chk("dual3_end");

    // 3-wire, 10 segments, aborted after 5 transfers.
    offer("abt", 2'd0, 16'd9, 1'b0);
    seg("abt_s0", 1'b1, 1'b0, 16'd9);
    seg("abt_s1", 1'b0, 1'b0, 16'd8);
    seg("abt_s2", 1'b0, 1'b0, 16'd7);
    seg("abt_s3", 1'b0, 1'b1, 16'd6);
    seg("abt_s4", 1'b0, 1'b0, 16'd5);
    bus.abt = 1'b1;
    #2;
    chk("abt_cyc_vld", 32'(bus.que_vld), 32'd0);
    chk("abt_cyc_rdy", 32'(bus.ser_rdy), 32'd0);
    next_edge();
    bus.abt = 1'b0;
    idle_chk("abt_after");

    // Single-segment descriptor, offered while abort is (harmlessly) high in IDL.
    bus.abt = 1'b1;
    offer("len0", 2'd0, 16'd0, 1'b0);
    seg("len0_s0", 1'b1, 1'b1, 16'd0);
    idle_chk("len0_end");

    // Asynchronous reset in the middle of a descriptor with rem=4.
    offer("ares", 2'd1, 16'd6, 1'b0);
    seg("ares_s0", 1'b1, 1'b0, 16'd6);
    seg("ares_s1", 1'b0, 1'b0, 16'd5);
    chk("ares_pre_rem", 32'(bus.sts_rem), 32'd4);
    rst = 1'b0;
    #1;
    idle_chk("ares_async");
    #1;
    rst = 1'b1;
    offer("ares_new", 2'd3, 16'd0, 1'b0);
    seg("ares_new_s0", 1'b1, 1'b1, 16'd0);
    idle_chk("ares_new_end");

    // Back-to-back descriptors with dsc_vld held high.
    offer("b2b_a", 2'd3, 16'd1, 1'b1);
    seg("b2b_a_s0", 1'b1, 1'b1, 16'd1);
    seg("b2b_a_s1", 1'b0, 1'b1, 16'd0);
    bus.ser_vld = 1'b1;
    #2;
    chk("b2b_gap_rdy", 32'(bus.dsc_rdy), 32'd1);
    chk("b2b_gap_vld", 32'(bus.que_vld), 32'd0);
    next_edge();
    bus.dsc_vld = 1'b0;
    #1;
    chk("b2b_b_bsy", 32'(bus.sts_bsy), 32'd1);
    seg("b2b_b_s0", 1'b1, 1'b1, 16'd1);
    seg("b2b_b_s1", 1'b0, 1'b1, 16'd0);
    idle_chk("b2b_end");

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
